val2_shift_pipe: RTL and testbench

Pipelined, parametrised second-operand (Val2) generator for the EXE stage: produces the shifted/rotated/immediate operand and the shifter carry-out from the instruction's shift_operand field, Rm and Rs. It extends the existing single-cycle Val2 path with register-specified shifts, RRX, carry-out, a valid/ready handshake and hazard flush. It sits between ID/EXE operand forwarding and the ALU.

---
 rtl/val2_shift_pipe.sv | 224 ++++++++++++++++++++++
 tb/tb_val2_shift_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/val2_shift_pipe.sv
// val2_shift_pipe: two-stage Val2 operand generator for the EXE stage.
// Produces the shifted / rotated / immediate second operand plus the
// shifter carry-out from shift_operand, Rm and Rs, with a valid/ready
// handshake and a synchronous flush of in-flight entries.
//
// Optional feature macro: VAL2_REG_SHIFT_EN
//   defined   : register-specified shift amounts (shift_operand[4]==1) use val_rs
//   undefined : shift_operand[4]==1 behaves as LSL #0 and val_rs is ignored
//
// Stage 1 decodes the request form, shift type and amount and captures Rm.
// Stage 2 performs the shift/rotate and registers val2, carry_out and tag.
module val2_shift_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              imm,
  input  logic              mem_rw_en,
  input  logic [11:0]       shift_operand,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [7:0]        val_rs,
  input  logic              carry_in,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2,
  output logic              carry_out,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int LOG_W = $clog2(DATA_W);
`ifdef VAL2_REG_SHIFT_EN
  localparam int AMT_W = 9;
`else
  localparam int AMT_W = 5;
`endif

  // Decoded request form held in stage 1.
  //   FORM_MEM  : sign-extended offset, carry passes through
  //   FORM_IMM  : 8-bit immediate rotated right by the stored amount
  //   FORM_REG  : Rm shifted by the stored amount
  //   FORM_RRX  : rotate right through carry by one
  //   FORM_SH32 : LSR/ASR immediate #0, which means a shift by 32
  typedef enum logic [2:0] {
    FORM_MEM  = 3'd0,
    FORM_IMM  = 3'd1,
    FORM_REG  = 3'd2,
    FORM_RRX  = 3'd3,
    FORM_SH32 = 3'd4
  } form_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROR = 2'd3
  } shift_e;

  // Handshake: a transfer happens on a rising edge where valid and ready
  // are both high. in_ready depends combinationally on out_ready so a full
  // pipe keeps streaming at one per cycle; once out_valid is raised val2,
  // carry_out and out_tag hold until the consumer takes them. flush kills
  // both stages and wins over a request presented in the same cycle.
  logic s1_valid, s2_valid;
  logic s1_advance, s2_advance, accept;

  assign s2_advance = !s2_valid || out_ready;
  assign s1_advance = !s1_valid || s2_advance;
  assign in_ready   = s1_advance;
  assign accept     = in_valid && in_ready;

  // Stage 1 storage
  form_e              s1_form;
  shift_e             s1_type;
  logic [AMT_W-1:0]   s1_amt;
  logic [DATA_W-1:0]  s1_rm;
  logic               s1_cin;
  logic [TAG_W-1:0]   s1_tag;

  // Stage 1 next values
  form_e              d_form;
  shift_e             d_type;
  logic [AMT_W-1:0]   d_amt;
  logic [DATA_W-1:0]  d_rm;

`ifndef VAL2_REG_SHIFT_EN
  logic unused_val_rs;
  assign unused_val_rs = ^val_rs;
`endif

  // Decode the request into form, shift type, amount and operand source.
  always_comb begin
    d_form = FORM_REG;
    d_type = shift_e'(shift_operand[6:5]);
    d_amt  = '0;
    d_rm   = val_rm;
    if (mem_rw_en) begin
      d_form = FORM_MEM;
      d_type = SH_LSL;
      d_rm   = {{(DATA_W-12){shift_operand[11]}}, shift_operand};
    end else if (imm) begin
      d_form = FORM_IMM;
      d_type = SH_ROR;
      d_amt  = AMT_W'({shift_operand[11:8], 1'b0});
      d_rm   = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
    end else begin
      d_amt = AMT_W'(shift_operand[11:7]);
      if (shift_operand[11:7] == 5'd0) begin
        case (d_type)
          SH_LSR, SH_ASR: d_form = FORM_SH32;
          SH_ROR:         d_form = FORM_RRX;
          default:        d_form = FORM_REG;
        endcase
      end
      if (shift_operand[4]) begin
        d_form = FORM_REG;
`ifdef VAL2_REG_SHIFT_EN
        d_amt  = AMT_W'(val_rs);
`else
        d_type = SH_LSL;
        d_amt  = '0;
`endif
      end
    end
  end

  // Valid bits: flush and reset clear both stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_advance) s1_valid <= in_valid;
      if (s2_advance) s2_valid <= s1_valid;
    end
  end

  // Stage 1 data capture on every accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_form <= FORM_MEM;
      s1_type <= SH_LSL;
      s1_amt  <= '0;
      s1_rm   <= '0;
      s1_cin  <= 1'b0;
      s1_tag  <= '0;
    end else if (accept) begin
      s1_form <= d_form;
      s1_type <= d_type;
      s1_amt  <= d_amt;
      s1_rm   <= d_rm;
      s1_cin  <= carry_in;
      s1_tag  <= in_tag;
    end
  end

  // Shifter: each shift is done on a (DATA_W+1)-bit word so the bit that
  // falls off the end lands in the extra position and becomes the carry.
  logic [8:0]               n_eff;
  logic [LOG_W-1:0]         rot_amt;
  logic [DATA_W:0]          lsl_t, lsr_t;
  logic signed [DATA_W:0]   asr_t;
  logic [DATA_W-1:0]        rot_t;
  logic [DATA_W-1:0]        sh_val;
  logic                     sh_c;

  // Compute val2 and carry for the entry held in stage 1.
  always_comb begin
    n_eff   = (s1_form == FORM_SH32) ? 9'd32 : 9'(s1_amt);
    rot_amt = n_eff[LOG_W-1:0];
    lsl_t   = {1'b0, s1_rm} << n_eff;
    lsr_t   = {s1_rm, 1'b0} >> n_eff;
    asr_t   = $signed({s1_rm, 1'b0}) >>> n_eff;
    rot_t   = DATA_W'({s1_rm, s1_rm} >> rot_amt);
    sh_val  = s1_rm;
    sh_c    = s1_cin;
    case (s1_form)
      FORM_MEM: begin
        sh_val = s1_rm;
        sh_c   = s1_cin;
      end
      FORM_RRX: begin
        sh_val = {s1_cin, s1_rm[DATA_W-1:1]};
        sh_c   = s1_rm[0];
      end
      default: begin
        if (n_eff != 9'd0) begin
          case (s1_type)
            SH_LSL: {sh_c, sh_val} = lsl_t;
            SH_LSR: {sh_val, sh_c} = lsr_t;
            SH_ASR: {sh_val, sh_c} = asr_t;
            default: begin
              sh_val = rot_t;
              sh_c   = rot_t[DATA_W-1];
            end
          endcase
        end
      end
    endcase
  end

  // Stage 2 output registers, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val2      <= '0;
      carry_out <= 1'b0;
      out_tag   <= '0;
    end else if (s2_advance && s1_valid) begin
      val2      <= sh_val;
      carry_out <= sh_c;
      out_tag   <= s1_tag;
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_val2_shift_pipe.sv
// Bench for val2_shift_pipe: directed checks of reset, latency, operand
// forms, stall and flush, followed by randomized traffic scored against
// a behavioural model of the operand rules.
`timescale 1ns/1ps
module tb_val2_shift_pipe;

  localparam int W  = 32;
  localparam int TW = 4;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, in_valid, in_ready, imm, mem_rw_en, carry_in;
  logic [11:0]   shift_operand;
  logic [W-1:0]  val_rm;
  logic [7:0]    val_rs;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready, carry_out;
  logic [W-1:0]  val2;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  val2_shift_pipe #(.DATA_W(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .mem_rw_en(mem_rw_en), .shift_operand(shift_operand),
    .val_rm(val_rm), .val_rs(val_rs), .carry_in(carry_in), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .val2(val2), .carry_out(carry_out), .out_tag(out_tag)
  );

  int n_vec   = 0;
  int n_err   = 0;
  int n_deliv = 0;
  logic [TW-1:0] tag_ctr = '0;

  // {tag, carry, val2}
  logic [W+TW:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W:0] ref_val2(input logic m, input logic i, input logic [11:0] so,
                                          input logic [W-1:0] rm, input logic [7:0] rs,
                                          input logic cin);
    logic [W-1:0]        v;
    logic signed [W-1:0] sv;
    logic                c;
    int                  n, r, mm;
    logic [1:0]          typ;
    if (m) return {cin, {{(W-12){so[11]}}, so}};
    if (i) begin
      r = 2 * int'(so[11:8]);
      v = {24'd0, so[7:0]};
      if (r != 0) v = (v >> r) | (v << (W - r));
      c = (r == 0) ? cin : v[W-1];
      return {c, v};
    end
    typ = so[6:5];
    n   = int'(so[11:7]);
    if (so[4]) begin
`ifdef VAL2_REG_SHIFT_EN
      n = int'(rs);
`else
      return {cin, rm};
`endif
    end else if (n == 0) begin
      if (typ == 2'd3) return {rm[0], cin, rm[W-1:1]};
      if (typ == 2'd1 || typ == 2'd2) n = 32;
    end
    if (n == 0) return {cin, rm};
    case (typ)
      2'd0: begin
        if (n < W)       return {rm[W-n], rm << n};
        else if (n == W) return {rm[0], {W{1'b0}}};
        else             return '0;
      end
      2'd1: begin
        if (n < W)       return {rm[n-1], rm >> n};
        else if (n == W) return {rm[W-1], {W{1'b0}}};
        else             return '0;
      end
      2'd2: begin
        if (n < W) begin
          sv = $signed(rm) >>> n;
          return {rm[n-1], sv};
        end
        return {rm[W-1], {W{rm[W-1]}}};
      end
      default: begin
        mm = n % W;
        if (mm == 0) return {rm[W-1], rm};
        v = (rm >> mm) | (rm << (W - mm));
        return {rm[mm-1], v};
      end
    endcase
  endfunction

  // ---------------- scoreboard (samples on falling edge) ----------------
  always @(negedge clk) begin
    logic [W+TW:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          e = exp_q[0];
          check_val("sb_val2", val2, e[W-1:0]);
          check_val("sb_carry", carry_out, e[W]);
          check_val("sb_tag", out_tag, e[W+TW:W+1]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_deliv++;
          end
        end
      end
      if (flush) exp_q.delete();
      if (in_valid && in_ready && !flush)
        exp_q.push_back({in_tag, ref_val2(mem_rw_en, imm, shift_operand, val_rm, val_rs, carry_in)});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic m, input logic i, input logic [11:0] so,
                         input logic [W-1:0] rm, input logic [7:0] rs, input logic cin);
    in_valid      = 1'b1;
    mem_rw_en     = m;
    imm           = i;
    shift_operand = so;
    val_rm        = rm;
    val_rs        = rs;
    carry_in      = cin;
    in_tag        = tag_ctr;
    tag_ctr       = tag_ctr + 1'b1;
  endtask

  // Present a request, wait (bounded) until accepted, return at edge+1.
  task automatic push_req(input logic m, input logic i, input logic [11:0] so,
                          input logic [W-1:0] rm, input logic [7:0] rs, input logic cin);
    bit ok;
    set_req(m, i, so, rm, rs, cin);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_val("accept_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // One isolated request: checks the 2-cycle latency and the result.
  task automatic single(input string name, input logic m, input logic i, input logic [11:0] so,
                        input logic [W-1:0] rm, input logic [7:0] rs, input logic cin,
                        input logic [W-1:0] ev, input logic ec);
    out_ready = 1'b1;
    push_req(m, i, so, rm, rs, cin);
    check_val({name, "_lat1"}, out_valid, 1'b0);
    @(posedge clk); #1;
    check_val({name, "_lat2"}, out_valid, 1'b1);
    check_val({name, "_val2"}, val2, ev);
    check_val({name, "_c"}, carry_out, ec);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 30; k++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    check_val({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    rst_n = 1'b1; flush = 0; in_valid = 0; imm = 0; mem_rw_en = 0;
    shift_operand = '0; val_rm = '0; val_rs = '0; carry_in = 0; in_tag = '0; out_ready = 1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_val2", val2, '0);
    check_val("rst_carry", carry_out, 1'b0);
    check_val("rst_tag", out_tag, '0);
    @(negedge clk); rst_n = 1'b1;
    #1 check_val("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Immediate and memory forms
    single("imm_4ff", 0, 1, 12'h4FF, 32'h12345678, 8'd0, 0, 32'hFF000000, 1'b1);
    single("imm_0ab", 0, 1, 12'h0AB, 32'h12345678, 8'd0, 1, 32'h000000AB, 1'b1);
    single("mem_pri", 1, 1, 12'hFFC, 32'h12345678, 8'd0, 1, 32'hFFFFFFFC, 1'b1);
    single("mem_pos", 1, 0, 12'h7F0, 32'h0, 8'd0, 0, 32'h000007F0, 1'b0);

    // Immediate-amount register forms
    single("rrx", 0, 0, 12'h060, 32'h00000001, 8'd0, 1, 32'h80000000, 1'b1);
    single("lsr_i0", 0, 0, 12'h020, 32'h80000001, 8'd0, 0, 32'h00000000, 1'b1);
    single("asr_i0", 0, 0, 12'h040, 32'h80000001, 8'd0, 0, 32'hFFFFFFFF, 1'b1);
    single("asr_i4", 0, 0, 12'h240, 32'h80000018, 8'd0, 0, 32'hF8000001, 1'b1);
    single("lsl_i1", 0, 0, 12'h080, 32'h80000001, 8'd0, 0, 32'h00000002, 1'b1);
    single("lsl_i0", 0, 0, 12'h000, 32'h80000001, 8'd0, 1, 32'h80000001, 1'b1);

    // Register-specified amounts
`ifdef VAL2_REG_SHIFT_EN
    single("lsr_rs0",  0, 0, 12'h030, 32'h80000001, 8'd0,  1, 32'h80000001, 1'b1);
    single("lsr_rs1",  0, 0, 12'h030, 32'h80000001, 8'd1,  0, 32'h40000000, 1'b1);
    single("lsr_rs32", 0, 0, 12'h030, 32'h80000001, 8'd32, 0, 32'h00000000, 1'b1);
    single("lsr_rs33", 0, 0, 12'h030, 32'h80000001, 8'd33, 1, 32'h00000000, 1'b0);
    single("ror_rs32", 0, 0, 12'h070, 32'h80000001, 8'd32, 0, 32'h80000001, 1'b1);
`else
    single("lsr_rs0",  0, 0, 12'h030, 32'h80000001, 8'd0,  1, 32'h80000001, 1'b1);
    single("lsr_rs1",  0, 0, 12'h030, 32'h80000001, 8'd1,  0, 32'h80000001, 1'b0);
    single("lsr_rs33", 0, 0, 12'hFB0, 32'h80000001, 8'd33, 1, 32'h80000001, 1'b1);
    single("ror_rs32", 0, 0, 12'h070, 32'h80000001, 8'd32, 0, 32'h80000001, 1'b0);
`endif

    // Stall: four back-to-back requests with the consumer blocked
    d0 = n_deliv;
    out_ready = 1'b0;
    push_req(0, 1, 12'h1F0, 32'h0, 8'd0, 0);
    push_req(0, 0, 12'h0A0, 32'hDEADBEEF, 8'd0, 1);
    set_req(1, 0, 12'h800, 32'h0, 8'd0, 1);
    check_val("stall_in_ready", in_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_val("stall_hold_ready", in_ready, 1'b0);
      check_val("stall_hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    push_req(mem_rw_en, imm, shift_operand, val_rm, val_rs, carry_in);
    push_req(0, 0, 12'h3E0, 32'h00000004, 8'd0, 0);
    drain("stall");
    check_val("stall_delivered", 64'(n_deliv - d0), 64'd4);

    // Flush with two in flight plus a new request in the same cycle
    out_ready = 1'b0;
    push_req(0, 1, 12'h3C5, 32'h0, 8'd0, 0);
    push_req(0, 0, 12'h100, 32'h0000FFFF, 8'd0, 0);
    set_req(1, 0, 12'h123, 32'h0, 8'd0, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_val("flush_empty", out_valid, 1'b0);
      @(posedge clk); #1;
    end
    single("after_flush", 0, 1, 12'h201, 32'h0, 8'd0, 0, 32'h10000000, 1'b0);

    // Reset mid-stream with two entries in flight
    out_ready = 1'b0;
    push_req(0, 1, 12'h0FF, 32'h0, 8'd0, 1);
    push_req(0, 0, 12'h080, 32'hFFFFFFFF, 8'd0, 1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", out_valid, 1'b0);
    check_val("midrst_val2", val2, '0);
    check_val("midrst_carry", carry_out, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check_val("midrst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("midrst_no_out", out_valid, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      out_ready     = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 24) == 0);
      in_valid      = ($urandom_range(0, 3) != 0);
      mem_rw_en     = ($urandom_range(0, 7) == 0);
      imm           = ($urandom_range(0, 3) == 0);
      shift_operand = 12'($urandom_range(0, 4095));
      val_rm        = $urandom;
      val_rs        = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
      carry_in      = 1'($urandom_range(0, 1));
      in_tag        = TW'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
